// File: rtl/pattern_scan_if.sv
// Byte-stream input and per-frame result output of the pattern scan controller.
// Both channels transfer on a cycle where valid && ready; valid and its payload hold until then.
interface pattern_scan_if #(
  parameter int CNT_W = 8
);
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic [CNT_W-1:0] m_count;
  logic             m_overflow;
  logic             m_ready;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_count, m_overflow
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_count, m_overflow
  );
endinterface

// File: rtl/pattern_scan_controller.sv
// Serialises a byte stream MSB-first and counts overlapping matches of a
// programmable 1..PAT_W bit pattern per frame, one result beat per frame.
module pattern_scan_controller #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_load,
  pattern_scan_if.slave    bus,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [3:0]       PAT_LEN = 4'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [7:0]       data_q;
  logic             last_q;
  logic [2:0]       idx;
  logic [PAT_W-1:0] history;
  logic [3:0]       bits_seen;
  logic             frame_active;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       len_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic [PAT_W-1:0] hist_next;
  logic [3:0]       seen_next;
  logic [PAT_W-1:0] len_mask;
  logic [3:0]       len_clamped;
  logic             match;
  logic             cfg_take;

  // The match looks at the history that already contains the bit being shifted now.
  always_comb begin
    hist_next = {history[PAT_W-2:0], data_q[idx]};
    seen_next = (bits_seen == PAT_LEN) ? bits_seen : bits_seen + 4'd1;
    len_mask  = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = (state == SHIFT) && (len_q != 4'd0) && (seen_next >= len_q) &&
            (((hist_next ^ pat_q) & len_mask) == '0);
  end

  assign len_clamped = (int'(cfg_len) > PAT_W) ? PAT_LEN : cfg_len;
  // Config only changes between frames, so a frame never sees two patterns.
  assign cfg_take    = cfg_load && (state == ACCEPT) && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACCEPT;
      data_q       <= '0;
      last_q       <= 1'b0;
      idx          <= '0;
      history      <= '0;
      bits_seen    <= '0;
      frame_active <= 1'b0;
      pat_q        <= '0;
      len_q        <= PAT_LEN;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (cfg_take) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
      end
      case (state)
        ACCEPT: begin
          if (bus.s_valid) begin
            data_q       <= bus.s_data;
            last_q       <= bus.s_last;
            frame_active <= 1'b1;
            idx          <= 3'd7;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          history   <= hist_next;
          bits_seen <= seen_next;
          if (match) begin
            if (count_q == CNT_MAX) overflow_q <= 1'b1;
            else                    count_q    <= count_q + 1'b1;
          end
          idx <= idx - 3'd1;
          if (idx == 3'd0) state <= last_q ? REPORT : ACCEPT;
        end
        REPORT: begin
          if (bus.m_ready) begin
            count_q      <= '0;
            overflow_q   <= 1'b0;
            history      <= '0;
            bits_seen    <= '0;
            frame_active <= 1'b0;
            state        <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign bus.s_ready    = (state == ACCEPT);
  assign bus.m_valid    = (state == REPORT);
  assign bus.m_count    = count_q;
  assign bus.m_overflow = overflow_q;
  assign busy           = frame_active || (state == REPORT);
  assign state_dbg      = state;

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed and randomized frames for pattern_scan_controller, scored against
// a bit-list reference model of the overlapping match count.
module tb_pattern_scan_controller;
  localparam int PAT_W   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_load;
  logic             busy;
  logic [1:0]       state_dbg;

  pattern_scan_if #(.CNT_W(CNT_W)) bus ();

  pattern_scan_controller #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_load    (cfg_load),
    .bus         (bus.slave),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]       frame_q[$];
  logic [CNT_W:0]   exp_q[$];
  logic [PAT_W-1:0] model_pat;
  int               model_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expand the frame to a bit list and slide a len-bit window over it.
  function automatic logic [CNT_W:0] model_frame();
    int bits[$];
    int raw = 0;
    foreach (frame_q[i])
      for (int b = 7; b >= 0; b--) bits.push_back(int'(frame_q[i][b]));
    for (int k = 0; k < bits.size(); k++) begin
      if (model_len != 0 && k + 1 >= model_len) begin
        bit ok = 1'b1;
        for (int j = 0; j < model_len; j++)
          if (bits[k-j] != int'(model_pat[j])) ok = 1'b0;
        if (ok) raw++;
      end
    end
    if (raw > CNT_MAX) return {1'b1, CNT_W'(CNT_MAX)};
    return {1'b0, CNT_W'(raw)};
  endfunction

  // driver tasks
  task automatic load_cfg(input logic [PAT_W-1:0] pat, input int len, input bit model_sees);
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_load    = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    if (model_sees) begin
      model_pat = pat;
      model_len = (len > PAT_W) ? PAT_W : len;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic shift_phase(input bit glitch);
    int n = 0;
    while (!bus.s_ready && !bus.m_valid && n < 20) begin
      n++;
      if (glitch && n == 3) begin
        cfg_pattern = '0;
        cfg_len     = 4'd4;
        cfg_load    = 1'b1;
      end
      @(negedge clk);
      cfg_load = 1'b0;
    end
    check("shift_cycles", 32'(n), 32'd8);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit glitch);
    wait_ready();
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    shift_phase(glitch);
  endtask

  task automatic send_frame();
    exp_q.push_back(model_frame());
    foreach (frame_q[i]) send_byte(frame_q[i], (i == frame_q.size() - 1), 1'b0);
  endtask

  task automatic get_result(input int hold);
    int n = 0;
    logic [CNT_W:0] exp;
    while (!bus.m_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.m_valid) check("m_valid_timeout", 32'(bus.m_valid), 32'd1);
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_m_valid", 32'(bus.m_valid), 32'd1);
      check("hold_m_count", 32'(bus.m_count), 32'(exp[CNT_W-1:0]));
      check("hold_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    check("m_count", 32'(bus.m_count), 32'(exp[CNT_W-1:0]));
    check("m_overflow", 32'(bus.m_overflow), 32'(exp[CNT_W]));
    check("busy_report", 32'(busy), 32'd1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("post_m_valid", 32'(bus.m_valid), 32'd0);
    check("post_s_ready", 32'(bus.s_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_count"}, 32'(bus.m_count), 32'd0);
    check({tag, "_m_overflow"}, 32'(bus.m_overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_load    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    model_pat   = '0;
    model_len   = PAT_W;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // single byte, two overlapping matches
    load_cfg(8'h0B, 4, 1'b1);
    frame_q = '{8'hB6};
    send_frame();
    get_result(0);

    // match spanning a byte boundary
    frame_q = '{8'h01, 8'h60};
    send_frame();
    get_result(0);

    // saturation, then a clean frame
    load_cfg(8'h0F, 4, 1'b1);
    frame_q = {};
    for (int i = 0; i < 33; i++) frame_q.push_back(8'hFF);
    send_frame();
    get_result(0);
    frame_q = '{8'h00};
    send_frame();
    get_result(0);

    // result held under back-pressure
    load_cfg(8'h0B, 4, 1'b1);
    frame_q = '{8'hB6};
    send_frame();
    get_result(5);

    // config pulses inside a frame are ignored
    frame_q = '{8'hB6, 8'hB6};
    exp_q.push_back(model_frame());
    send_byte(8'hB6, 1'b0, 1'b1);
    load_cfg(8'h00, 4, 1'b0);
    send_byte(8'hB6, 1'b1, 1'b0);
    get_result(0);

    // zero length never matches
    load_cfg(8'h0B, 0, 1'b1);
    frame_q = '{8'hB6};
    send_frame();
    get_result(0);

    // length 12 clamps to 8
    load_cfg(8'hB6, 12, 1'b1);
    frame_q = '{8'hB6, 8'hB6};
    send_frame();
    get_result(0);

    // config coinciding with the first byte applies to it
    model_pat = 8'h0B;
    model_len = 4;
    frame_q = '{8'hB6};
    exp_q.push_back(model_frame());
    wait_ready();
    cfg_pattern = 8'h0B;
    cfg_len     = 4'd4;
    cfg_load    = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hB6;
    bus.s_last  = 1'b1;
    @(negedge clk);
    cfg_load    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    shift_phase(1'b0);
    get_result(0);

    // reset in the middle of the second byte
    load_cfg(8'h0B, 4, 1'b1);
    send_byte(8'hB6, 1'b0, 1'b0);
    wait_ready();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h2D;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset     = 1'b0;
    model_pat = '0;
    model_len = PAT_W;
    @(negedge clk);
    check_reset_outputs("after_reset");
    load_cfg(8'h0B, 4, 1'b1);
    frame_q = '{8'hB6};
    send_frame();
    get_result(0);

    // randomized frames and configurations
    for (int f = 0; f < 16; f++) begin
      load_cfg(PAT_W'($urandom), int'($urandom_range(0, 10)), 1'b1);
      frame_q = {};
      for (int b = 0; b < int'($urandom_range(1, 4)); b++) frame_q.push_back(8'($urandom));
      send_frame();
      get_result(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
